map_mem_arbiter: RTL and testbench

//  Owns the single-port map RAM of the drone datapath. On the controller's restore

---
 rtl/map_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_map_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter
//   Owns the single-port map RAM. A rising edge on restore_i copies one ROM map bank
//   into RAM (N_CELLS cells) and then raises fim_restore_o until restore_i falls.
//   Outside a copy, the RAM read port is shared between the collision checker (col_*)
//   and the display scanner (disp_*), one read per cycle. Collision has priority, but
//   the display wins the next slot after DISP_MAX_WAIT consecutive denials.
//
//   Optional feature macro: MAP_SUM_EN adds map_sum_o, the mod-256 sum of the cells
//   written by the last copy. Without it the port and adder are absent.
//
//   Ports
//     clock_i, reset_i          clock, synchronous active-low reset
//     restore_i, mapa_sel_i     copy request (edge-started) and ROM bank select
//     rom_addr_o, rom_data_i    ROM interface {bank, cell}, 1-cycle read latency
//     fim_restore_o             copy complete, held until restore_i falls
//     col_*/disp_*              read ports: req/addr in, gnt/valid/data out
//     ram_*                     RAM interface, 1-cycle read latency
//     busy_o, db_estado_o       copy in progress, debug state code
//
//   state | meaning
//   IDLE  | waiting; arbitrates reads; restore edge starts a copy
//   COPY  | issuing ROM reads, writing the previous cell each cycle
//   LAST  | writing the final cell
//   DONE  | copy complete; arbitrates reads until restore falls
module map_mem_arbiter #(
    parameter int ADDR_W        = 6,
    parameter int DATA_W        = 4,
    parameter int N_CELLS       = 64,
    parameter int DISP_MAX_WAIT = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              restore_i,
    input  logic [1:0]        mapa_sel_i,
    output logic [ADDR_W+1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              fim_restore_o,
    input  logic              col_req_i,
    input  logic [ADDR_W-1:0] col_addr_i,
    output logic              col_gnt_o,
    output logic              col_valid_o,
    output logic [DATA_W-1:0] col_data_o,
    input  logic              disp_req_i,
    input  logic [ADDR_W-1:0] disp_addr_i,
    output logic              disp_gnt_o,
    output logic              disp_valid_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
`ifdef MAP_SUM_EN
    output logic [7:0]        map_sum_o,
`endif
    output logic              busy_o,
    output logic [3:0]        db_estado_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CELLS - 1);
    localparam int CNT_W = $clog2(DISP_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DISP_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        sel_q, sel_d;
    logic              restore_q;
    logic [CNT_W-1:0]  starv_q, starv_d;
    logic              col_valid_q, disp_valid_q;
    logic [DATA_W-1:0] col_hold_q, disp_hold_q;

    logic              rise;
    logic              can_grant;
    logic              disp_wins;

    assign rise = restore_i & ~restore_q;
    // Display has waited long enough: it takes this slot even if col is requesting.
    assign disp_wins = disp_req_i && (starv_q >= CNT_MAX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        starv_d     = starv_q;
        can_grant   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        col_gnt_o   = 1'b0;
        disp_gnt_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COPY;
                    sel_d   = mapa_sel_i;
                    idx_d   = '0;
                end else begin
                    can_grant = 1'b1;
                end
            end
            COPY: begin
                if (!restore_i) begin
                    state_d = IDLE;
                end else begin
                    // rom_data_i now holds the cell addressed last cycle (idx-1).
                    if (idx_q != '0) begin
                        ram_we_o    = 1'b1;
                        ram_addr_o  = idx_q - ADDR_W'(1);
                        ram_wdata_o = rom_data_i;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = LAST;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            LAST: begin
                if (!restore_i) begin
                    state_d = IDLE;
                end else begin
                    ram_we_o    = 1'b1;
                    ram_addr_o  = idx_q;
                    ram_wdata_o = rom_data_i;
                    state_d     = DONE;
                end
            end
            DONE: begin
                can_grant = 1'b1;
                if (!restore_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (can_grant && reset_i) begin
            if (col_req_i && !disp_wins) begin
                col_gnt_o  = 1'b1;
                ram_addr_o = col_addr_i;
            end else if (disp_req_i) begin
                disp_gnt_o = 1'b1;
                ram_addr_o = disp_addr_i;
            end
        end

        if (!reset_i) begin
            ram_we_o = 1'b0;
        end

        if (!disp_req_i || disp_gnt_o) begin
            starv_d = '0;
        end else if (starv_q != CNT_MAX) begin
            starv_d = starv_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            sel_q        <= '0;
            restore_q    <= 1'b0;
            starv_q      <= '0;
            col_valid_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            col_hold_q   <= '0;
            disp_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sel_q        <= sel_d;
            restore_q    <= restore_i;
            starv_q      <= starv_d;
            col_valid_q  <= col_gnt_o;
            disp_valid_q <= disp_gnt_o;
            if (col_valid_q) begin
                col_hold_q <= ram_rdata_i;
            end
            if (disp_valid_q) begin
                disp_hold_q <= ram_rdata_i;
            end
        end
    end

    // Read data is passed straight through in the valid cycle and held afterwards.
    assign col_valid_o   = col_valid_q;
    assign disp_valid_o  = disp_valid_q;
    assign col_data_o    = col_valid_q  ? ram_rdata_i : col_hold_q;
    assign disp_data_o   = disp_valid_q ? ram_rdata_i : disp_hold_q;
    assign rom_addr_o    = {sel_q, idx_q};
    assign fim_restore_o = (state_q == DONE);
    assign busy_o        = (state_q == COPY) || (state_q == LAST);
    assign db_estado_o   = {2'b00, state_q};

`ifdef MAP_SUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            sum_q <= '0;
        end else if (state_q == IDLE && rise) begin
            sum_q <= '0;
        end else if (ram_we_o) begin
            sum_q <= sum_q + 8'(rom_data_i);
        end
    end

    assign map_sum_o = sum_q;
`endif

endmodule

// File: tb/tb_map_mem_arbiter.sv
module tb_map_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       restore;
    logic [1:0] mapa_sel;
    logic [7:0] rom_addr;
    logic [3:0] rom_data;
    logic       fim;
    logic       col_req, col_gnt, col_valid;
    logic [5:0] col_addr;
    logic [3:0] col_data;
    logic       disp_req, disp_gnt, disp_valid;
    logic [5:0] disp_addr;
    logic [3:0] disp_data;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;
    logic       busy;
    logic [3:0] db_estado;
`ifdef MAP_SUM_EN
    logic [7:0] map_sum;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] ram     [64];
    logic [3:0] exp_ram [64];
    logic [3:0] col_sb  [$];
    logic [3:0] disp_sb [$];

    map_mem_arbiter dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .restore_i    (restore),
        .mapa_sel_i   (mapa_sel),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .fim_restore_o(fim),
        .col_req_i    (col_req),
        .col_addr_i   (col_addr),
        .col_gnt_o    (col_gnt),
        .col_valid_o  (col_valid),
        .col_data_o   (col_data),
        .disp_req_i   (disp_req),
        .disp_addr_i  (disp_addr),
        .disp_gnt_o   (disp_gnt),
        .disp_valid_o (disp_valid),
        .disp_data_o  (disp_data),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata),
`ifdef MAP_SUM_EN
        .map_sum_o    (map_sum),
`endif
        .busy_o       (busy),
        .db_estado_o  (db_estado)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank 2 holds i%16 so the copy result is easy to recognise; other banks are scrambled.
    function automatic logic [3:0] rom_val(input logic [1:0] b, input logic [5:0] i);
        logic [7:0] t;
        if (b == 2'd2) return i[3:0];
        t = 8'(i) * 8'd3 + 8'(b) * 8'd5 + 8'd1;
        return t[3:0];
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr[7:6], rom_addr[5:0]);

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        compared++;
        if ({col_gnt, disp_gnt, col_valid, disp_valid, ram_we, fim, busy} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_ctl got=%b want=0000000",
                     {col_gnt, disp_gnt, col_valid, disp_valid, ram_we, fim, busy});
        end
        compared++;
        if (db_estado !== 4'd0 || rom_addr !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_state got=%0d/%0h want=0/0", db_estado, rom_addr);
        end
        compared++;
        if (col_data !== 4'd0 || disp_data !== 4'd0) begin
            mismatched++;
            $display("FAIL reset_data got=%h/%h want=0/0", col_data, disp_data);
        end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_restore();
        int first;
        logic [3:0] e_st;
        logic [7:0] e_sum;
        first = -1;
        e_sum = 8'd0;
        for (int i = 0; i < 64; i++) begin
            exp_ram[i] = rom_val(2'd2, 6'(i));
            e_sum = e_sum + 8'(exp_ram[i]);
        end
        mapa_sel = 2'd2;
        restore  = 1'b1;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            if (fim && first < 0) first = k;
            e_st = (k == 0) ? 4'd0 : (k <= 64) ? 4'd1 : (k == 65) ? 4'd2 : 4'd3;
            compared++;
            if (db_estado !== e_st || busy !== (k >= 1 && k <= 65)) begin
                mismatched++;
                $display("FAIL restore_state k=%0d got=%0d busy=%b want=%0d", k, db_estado, busy, e_st);
            end
            step();
            if (k == 5) mapa_sel = 2'd0;
        end
        compared++;
        if (first !== 66) begin
            mismatched++;
            $display("FAIL restore_latency got=%0d want=66", first);
        end
        for (int i = 0; i < 64; i++) begin
            compared++;
            if (ram[i] !== exp_ram[i]) begin
                mismatched++;
                $display("FAIL restore_ram[%0d] got=%h want=%h", i, ram[i], exp_ram[i]);
            end
        end
`ifdef MAP_SUM_EN
        compared++;
        if (map_sum !== e_sum) begin
            mismatched++;
            $display("FAIL map_sum got=%h want=%h", map_sum, e_sum);
        end
`endif
        restore = 1'b0;
        step();
        @(negedge clk);
        compared++;
        if (db_estado !== 4'd0 || fim !== 1'b0) begin
            mismatched++;
            $display("FAIL restore_release got=%0d fim=%b want=0 fim=0", db_estado, fim);
        end
        step();
    endtask

    task automatic test_arbitration();
        bit pc, pd;
        logic [3:0] e;
        pc = 1'b0;
        pd = 1'b0;
        col_addr  = 6'd3;
        disp_addr = 6'd40;
        col_req   = 1'b1;
        disp_req  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            compared++;
            if (col_gnt !== (c < 12 && c % 5 != 4) || disp_gnt !== (c < 12 && c % 5 == 4)) begin
                mismatched++;
                $display("FAIL arb_gnt c=%0d got=%b%b want=%b%b", c, col_gnt, disp_gnt,
                         (c < 12 && c % 5 != 4), (c < 12 && c % 5 == 4));
            end
            compared++;
            if (col_valid !== pc || disp_valid !== pd) begin
                mismatched++;
                $display("FAIL arb_valid c=%0d got=%b%b want=%b%b", c, col_valid, disp_valid, pc, pd);
            end
            if (col_gnt) col_sb.push_back(exp_ram[col_addr]);
            if (disp_gnt) disp_sb.push_back(exp_ram[disp_addr]);
            if (col_valid && col_sb.size() > 0) begin
                e = col_sb.pop_front();
                compared++;
                if (col_data !== e) begin
                    mismatched++;
                    $display("FAIL arb_col_data c=%0d got=%h want=%h", c, col_data, e);
                end
            end
            if (disp_valid && disp_sb.size() > 0) begin
                e = disp_sb.pop_front();
                compared++;
                if (disp_data !== e) begin
                    mismatched++;
                    $display("FAIL arb_disp_data c=%0d got=%h want=%h", c, disp_data, e);
                end
            end
            pc = col_gnt;
            pd = disp_gnt;
            step();
            if (pc) col_addr = col_addr + 6'd5;
            if (pd) disp_addr = disp_addr + 6'd7;
            if (c == 11) begin
                col_req  = 1'b0;
                disp_req = 1'b0;
            end
        end
        compared++;
        if (col_sb.size() != 0 || disp_sb.size() != 0) begin
            mismatched++;
            $display("FAIL arb_drain got=%0d/%0d want=0/0", col_sb.size(), disp_sb.size());
        end
        col_sb.delete();
        disp_sb.delete();
    endtask

    task automatic test_abort();
        bit fim_seen;
        fim_seen = 1'b0;
        mapa_sel = 2'd2;
        restore  = 1'b1;
        repeat (10) step();
        restore = 1'b0;
        @(negedge clk);
        compared++;
        if (db_estado !== 4'd1) begin
            mismatched++;
            $display("FAIL abort_pre got=%0d want=1", db_estado);
        end
        step();
        @(negedge clk);
        compared++;
        if (db_estado !== 4'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_idle got=%0d busy=%b want=0 busy=0", db_estado, busy);
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (fim) fim_seen = 1'b1;
            step();
        end
        compared++;
        if (fim_seen !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_fim got=%b want=0", fim_seen);
        end
    endtask

    task automatic test_copy_block();
        logic [3:0] e;
        for (int i = 0; i < 64; i++) exp_ram[i] = rom_val(2'd1, 6'(i));
        mapa_sel = 2'd1;
        restore  = 1'b1;
        col_req  = 1'b1;
        col_addr = 6'd9;
        for (int k = 0; k <= 66; k++) begin
            @(negedge clk);
            compared++;
            if (col_gnt !== (k == 66) || disp_gnt !== 1'b0) begin
                mismatched++;
                $display("FAIL block_gnt k=%0d got=%b%b want=%b0", k, col_gnt, disp_gnt, (k == 66));
            end
            if (col_gnt) col_sb.push_back(exp_ram[col_addr]);
            step();
            if (k == 1) mapa_sel = 2'd3;
        end
        col_req = 1'b0;
        @(negedge clk);
        compared++;
        if (col_valid !== 1'b1 || col_sb.size() == 0) begin
            mismatched++;
            $display("FAIL block_valid got=%b want=1", col_valid);
        end else begin
            e = col_sb.pop_front();
            compared++;
            if (col_data !== e) begin
                mismatched++;
                $display("FAIL block_data got=%h want=%h", col_data, e);
            end
        end
        col_sb.delete();
        for (int i = 0; i < 64; i++) begin
            compared++;
            if (ram[i] !== exp_ram[i]) begin
                mismatched++;
                $display("FAIL block_ram[%0d] got=%h want=%h", i, ram[i], exp_ram[i]);
            end
        end
        restore = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_midcopy();
        mapa_sel = 2'd2;
        restore  = 1'b1;
        repeat (31) step();
        @(negedge clk);
        compared++;
        if (rom_addr !== {2'd2, 6'd30} || db_estado !== 4'd1) begin
            mismatched++;
            $display("FAIL midcopy_idx got=%h st=%0d want=9e st=1", rom_addr, db_estado);
        end
        reset   = 1'b0;
        restore = 1'b0;
        step();
        @(negedge clk);
        compared++;
        if ({col_gnt, disp_gnt, col_valid, disp_valid, ram_we, fim, busy} !== 7'b0
            || db_estado !== 4'd0) begin
            mismatched++;
            $display("FAIL midcopy_reset got=%b st=%0d want=0000000 st=0",
                     {col_gnt, disp_gnt, col_valid, disp_valid, ram_we, fim, busy}, db_estado);
        end
        reset = 1'b1;
        step();
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || col_valid !== 1'b0 || disp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midcopy_after got=%b%b%b want=000", busy, col_valid, disp_valid);
        end
    endtask

    initial begin
        reset     = 1'b0;
        restore   = 1'b0;
        mapa_sel  = 2'd0;
        col_req   = 1'b0;
        col_addr  = 6'd0;
        disp_req  = 1'b0;
        disp_addr = 6'd0;
        test_reset();
        test_restore();
        test_arbitration();
        test_abort();
        test_copy_block();
        test_reset_midcopy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
